fan_speed_ctrl: RTL and testbench
=================================

// Module: fan_speed_ctrl
// PURPOSE
//  Button-driven fan speed controller. Debounces a raw push-button and steps a
//  4-level speed FSM (OFF->LOW->MID->HIGH->OFF). Emits a 2-bit level code plus
//  fan_on, which feed the 2-to-4 enabled decoder (decoder_2_4_en,
//  .code=level_code, .enable=fan_on) that drives the speed LEDs.
//  Also drives the fan motor PWM whose duty tracks the current level.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles to accept a button level (10 ms @100 MHz)
//  PWM_PERIOD       100        PWM period in clk cycles (>=2)
//  DUTY_LOW         30         high cycles per period at LOW  (0..PWM_PERIOD)
//  DUTY_MID         60         high cycles per period at MID
//  DUTY_HIGH        90         high cycles per period at HIGH
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst_n       in   1  asynchronous active-low reset
//  btn_raw     in   1  raw button, asynchronous, bouncy, 1 = pressed
//  btn_off     in   1  synchronous force-off request, level, 1 = force OFF
//  level_code  out  2  00 OFF, 01 LOW, 10 MID, 11 HIGH
//  fan_on      out  1  1 when level_code != 00
//  pwm_out     out  1  motor PWM
//  btn_pulse   out  1  one-cycle pulse per accepted press (debug/observability)
// BEHAVIOUR
//  Reset (rst_n=0, async): level_code=00, fan_on=0, pwm_out=0, btn_pulse=0,
//   sync flops/debounced level=0, all counters=0, active duty=0. Mid-operation
//   reset aborts any debounce/PWM period immediately; no press is remembered.
//  Input path: btn_raw -> 2-flop synchronizer -> debounce. Debounce counter
//   clears whenever the synchronized value equals the debounced level or toggles;
//   when it has differed for DEBOUNCE_CYCLES consecutive cycles the debounced
//   level takes the new value. Any glitch shorter than DEBOUNCE_CYCLES is dropped.
//  btn_pulse = 1 for exactly one cycle on the debounced 0->1 edge; release
//   (1->0) generates nothing. Holding the button gives exactly one step.
//  FSM (registered, state = level_code): on btn_pulse: OFF->LOW->MID->HIGH->OFF.
//   btn_off=1 forces OFF that cycle and has priority over a simultaneous
//   btn_pulse (result OFF, press discarded). level_code/fan_on update the cycle
//   after btn_pulse. Latency btn_raw stable-high -> level_code change:
//   DEBOUNCE_CYCLES+4 cycles (+1 depending on async sampling).
//  PWM: counter cnt free-runs 0..PWM_PERIOD-1 then wraps to 0; width
//   $clog2(PWM_PERIOD+1). Target duty selected combinationally from state
//   (OFF=0). Active duty is loaded only when cnt==PWM_PERIOD-1, so a level change
//   takes effect at the next period boundary (no runt pulses).
//   pwm_out registered: 1 iff cnt < active duty. Duty 0 -> constant 0;
//   duty == PWM_PERIOD -> constant 1. Force-off likewise waits for the boundary.
//  Elaboration check: any DUTY_* > PWM_PERIOD or PWM_PERIOD<2 -> $error.
// STRUCTURE
//  Package fan_pkg: localparams LVL_OFF=2'b00, LVL_LOW=2'b01, LVL_MID=2'b10,
//   LVL_HIGH=2'b11, shared by this block and the LED/display logic.
//  Sub-module btn_debounce (#DEBOUNCE_CYCLES; clk, rst_n, btn_raw -> btn_level,
//   btn_pulse): synchronizer + debounce + rising-edge detect. FSM and PWM stay
//   in the top.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, PWM_PERIOD=10, DUTY 3/6/9)
//  1 Reset: rst_n=0 mid-run -> all outputs 0 immediately; release, idle 50 cyc ->
//    level_code=00, pwm_out stays 0.
//  2 Clean presses x4 (high 10 cyc, low 10 cyc) -> level_code 01,10,11,00 in turn,
//    exactly 4 btn_pulse; press 1 level change at DEBOUNCE_CYCLES+4(+1) cycles.
//  3 Bounce: 3-cycle high glitches x5 then stable high 10 cyc -> one btn_pulse,
//    level_code 00->01 only; 3-cycle low glitch during hold -> no extra pulse.
//  4 PWM: at LOW measure 3 high/7 low per 10-cycle period; press to MID mid-period
//    -> current period completes at 3, next period 6 high; HIGH -> 9 high/1 low.
//  5 btn_off at HIGH -> level_code 00 next cycle, pwm_out 0 from next boundary;
//    btn_off coinciding with btn_pulse at MID -> 00 (not HIGH).
//  6 Hold button 100 cyc -> exactly one step; reset asserted mid-debounce ->
//    no press registered after release.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan level encoding, used by the speed controller and the LED/display logic.
package fan_pkg;

  localparam logic [1:0] LVL_OFF  = 2'b00;
  localparam logic [1:0] LVL_LOW  = 2'b01;
  localparam logic [1:0] LVL_MID  = 2'b10;
  localparam logic [1:0] LVL_HIGH = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF  = LVL_OFF,
    ST_LOW  = LVL_LOW,
    ST_MID  = LVL_MID,
    ST_HIGH = LVL_HIGH
  } fan_state_t;

  // One button step around the ring OFF -> LOW -> MID -> HIGH -> OFF.
  function automatic fan_state_t next_level(input fan_state_t s);
    case (s)
      ST_OFF:  return ST_LOW;
      ST_LOW:  return ST_MID;
      ST_MID:  return ST_HIGH;
      default: return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce, and a one-cycle
// pulse on each accepted press (debounced 0->1). Releases produce no pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;
  logic          level_q;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      btn_level  <= 1'b0;
    end else if (sync_q2 == btn_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      btn_level  <= sync_q2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Rising-edge detect on the debounced level gives one pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      level_q   <= btn_level;
      btn_pulse <= btn_level & ~level_q;
    end
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Button-driven fan speed controller: debounced button steps a 4-level FSM,
// which selects the motor PWM duty and drives the level code for the LEDs.
//
//   state   | meaning
//   --------+-------------------------------------
//   ST_OFF  | fan stopped, PWM duty 0
//   ST_LOW  | low speed,  PWM duty DUTY_LOW
//   ST_MID  | mid speed,  PWM duty DUTY_MID
//   ST_HIGH | full speed, PWM duty DUTY_HIGH
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_PERIOD      = 100,
  parameter int DUTY_LOW        = 30,
  parameter int DUTY_MID        = 60,
  parameter int DUTY_HIGH       = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       btn_off,
  output logic [1:0] level_code,
  output logic       fan_on,
  output logic       pwm_out,
  output logic       btn_pulse
);

  if (PWM_PERIOD < 2 || DUTY_LOW > PWM_PERIOD || DUTY_MID > PWM_PERIOD ||
      DUTY_HIGH > PWM_PERIOD) begin : g_param_err
    $error("fan_speed_ctrl: PWM_PERIOD must be >= 2 and every DUTY_* <= PWM_PERIOD");
  end

  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  fan_state_t    state_q;
  fan_state_t    state_d;
  logic [CW-1:0] pwm_cnt;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] duty_target;
  // Debounced level is not needed by the FSM; kept on the instance for probing.
  logic          btn_level_unused;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level_unused),
    .btn_pulse(btn_pulse)
  );

  // Speed state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Next speed: force-off wins over a press arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (btn_off)        state_d = ST_OFF;
    else if (btn_pulse) state_d = next_level(state_q);
  end

  // Duty requested by the current speed.
  always_comb begin
    duty_target = '0;
    case (state_q)
      ST_LOW:  duty_target = CW'(DUTY_LOW);
      ST_MID:  duty_target = CW'(DUTY_MID);
      ST_HIGH: duty_target = CW'(DUTY_HIGH);
      default: duty_target = '0;
    endcase
  end

  // PWM: free-running period counter; duty only switches at the period boundary
  // so a speed change never truncates or stretches the pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < duty_act);
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt  <= '0;
        duty_act <= duty_target;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  assign level_code = state_q;
  assign fan_on     = (state_q != ST_OFF);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Bench for fan_speed_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a window-based behavioural model.
module tb_fan_speed_ctrl;

  localparam int DEB = 4;
  localparam int P   = 10;
  localparam int DL  = 3;
  localparam int DM  = 6;
  localparam int DH  = 9;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       btn_raw = 1'b0;
  logic       btn_off = 1'b0;
  logic [1:0] level_code;
  logic       fan_on;
  logic       pwm_out;
  logic       btn_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_seen = 0;

  // model state
  bit hist[$];
  bit m_deb, m_deb_d, m_pulse;
  int m_lvl, m_k, m_duty, m_pwm;

  fan_speed_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PWM_PERIOD     (P),
    .DUTY_LOW       (DL),
    .DUTY_MID       (DM),
    .DUTY_HIGH      (DH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_off   (btn_off),
    .level_code(level_code),
    .fan_on    (fan_on),
    .pwm_out   (pwm_out),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int duty_of(input int lvl);
    case (lvl)
      1:       return DL;
      2:       return DM;
      3:       return DH;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    m_deb = 0; m_deb_d = 0; m_pulse = 0;
    m_lvl = 0; m_k = 0; m_duty = 0; m_pwm = 0;
  endtask

  // One clock edge of the reference: debounce as "last DEB synchronized samples
  // all disagree with the accepted level", PWM from the edge count since reset.
  task automatic model_edge();
    bit all_diff;
    bit n_deb, n_pulse;
    int n_lvl, n_duty, n_pwm, pos;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(btn_raw);
    void'(hist.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (hist[i] == m_deb) all_diff = 1'b0;
    pos     = m_k % P;
    n_pwm   = (pos < m_duty) ? 1 : 0;
    n_duty  = (pos == P - 1) ? duty_of(m_lvl) : m_duty;
    n_lvl   = btn_off ? 0 : (m_pulse ? (m_lvl + 1) % 4 : m_lvl);
    n_pulse = m_deb && !m_deb_d;
    n_deb   = all_diff ? !m_deb : m_deb;
    m_deb_d = m_deb;
    m_deb   = n_deb;
    m_pulse = n_pulse;
    m_lvl   = n_lvl;
    m_duty  = n_duty;
    m_pwm   = n_pwm;
    m_k++;
  endtask

  task automatic compare_all();
    check("level_code", int'(level_code), m_lvl);
    check("fan_on", int'(fan_on), (m_lvl != 0) ? 1 : 0);
    check("pwm_out", int'(pwm_out), m_pwm);
    check("btn_pulse", int'(btn_pulse), int'(m_pulse));
    pulse_seen += int'(btn_pulse);
  endtask

  // Called at a negedge; drives inputs, advances one cycle, returns at the next negedge.
  task automatic step(input logic raw, input logic off);
    btn_raw = raw;
    btn_off = off;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic press();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
  endtask

  task automatic pwm_window(output int highs);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      step(1'b0, 1'b0);
      highs += int'(pwm_out);
    end
  endtask

  // Async reset asserted between edges; outputs must clear at once.
  task automatic async_reset(input int hold_cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level_code", int'(level_code), 0);
    check("rst_fan_on", int'(fan_on), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_btn_pulse", int'(btn_pulse), 0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < hold_cycles; i++) step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, highs, seg_raw, seg_len, seg_off, guard;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("init_level_code", int'(level_code), 0);
    check("init_pwm_out", int'(pwm_out), 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    rst_n = 1'b1;

    // idle after reset
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      highs += int'(pwm_out);
    end
    check("idle_pwm_highs", highs, 0);
    check("idle_level", int'(level_code), 0);

    // clean presses with latency on the first
    pulse_seen = 0;
    lat = 0;
    while (lat < 20) begin
      step(1'b1, 1'b0);
      lat++;
      if (level_code != 2'd0) break;
    end
    check("press_latency", lat, DEB + 4);
    for (int i = lat; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("press1_level", int'(level_code), 1);
    press(); check("press2_level", int'(level_code), 2);
    press(); check("press3_level", int'(level_code), 3);
    press(); check("press4_level", int'(level_code), 0);
    check("press_pulse_count", pulse_seen, 4);

    // bouncing contact
    pulse_seen = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    end
    check("glitch_level", int'(level_code), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("bounce_pulse_count", pulse_seen, 1);
    check("bounce_level", int'(level_code), 1);

    // PWM duty per level
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    pwm_window(highs); check("pwm_low_highs", highs, DL);
    press();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    pwm_window(highs); check("pwm_mid_highs", highs, DM);
    press();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    pwm_window(highs); check("pwm_high_highs", highs, DH);

    // force off at HIGH
    step(1'b0, 1'b1);
    check("force_off_level", int'(level_code), 0);
    check("force_off_fan_on", int'(fan_on), 0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    pwm_window(highs); check("pwm_off_highs", highs, 0);

    // force off coinciding with a press at MID
    press(); press();
    check("pre_collide_level", int'(level_code), 2);
    guard = 0;
    while (guard < 20) begin
      step(1'b1, 1'b0);
      guard++;
      if (btn_pulse) break;
    end
    check("collide_pulse_seen", int'(btn_pulse), 1);
    step(1'b1, 1'b1);
    check("collide_level", int'(level_code), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("collide_after_level", int'(level_code), 0);

    // long hold gives a single step
    pulse_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("hold_pulse_count", pulse_seen, 1);
    check("hold_level", int'(level_code), 1);

    // reset in the middle of a debounce, with the fan running
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    btn_raw = 1'b0;
    async_reset(3);
    pulse_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    check("rst_mid_pulse_count", pulse_seen, 0);
    check("rst_mid_level", int'(level_code), 0);

    // random button traffic
    for (int s = 0; s < 150; s++) begin
      seg_raw = int'($urandom_range(0, 1));
      seg_len = int'($urandom_range(1, 12));
      seg_off = ($urandom_range(0, 29) == 0) ? 1 : 0;
      if ($urandom_range(0, 99) == 0) begin
        btn_raw = 1'b0;
        async_reset(2);
      end
      for (int i = 0; i < seg_len; i++)
        step(seg_raw[0], (i == 0 && seg_off == 1) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
